serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//   Receiving end of the serial link driven by the parallel-load shift register.
//   Collects WIDTH serial bits sampled on enabled clock edges and assembles them into a parallel word.
//   Presents the word to a consumer with a valid/ack handshake and flags words lost to overrun.
//   Sits between the serial line and the parallel datapath.
// PARAMETERS
//   WIDTH      4   bits per word (>=2)
//   MSB_FIRST  1   1: first received bit lands in DP[WIDTH-1]; 0: first bit lands in DP[0]
// PORTS
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous, active-low reset
//   D        in   1      serial data in
//   LS       in   1      shift enable: 1 = sample D on this edge
//   start    in   1      sync frame restart: discard partial word
//   ack      in   1      consumer accepts DP while valid=1
//   DP       out  WIDTH  last completed word
//   valid    out  1      DP holds an unacknowledged word
//   busy     out  1      partial word in progress (state SHIFT)
//   overrun  out  1      sticky: a completed word overwrote an unacked one
// BEHAVIOUR
// - Reset (rst=0, async): DP=0, valid=0, busy=0, overrun=0, bit count=0, shift reg=0, state IDLE.
// - States:
//   - IDLE: LS=1 samples the first bit, sets count=1 and moves to SHIFT.
//   - SHIFT: each LS=1 samples one bit and increments the count. LS=0 holds everything, so gaps are allowed.
//   - Sampling the WIDTH-th bit loads DP with the complete word on that same edge, sets count=0, returns to IDLE and sets valid=1.
// - Bit order:
//   - MSB_FIRST=1: shift left, D enters at bit 0.
//   - MSB_FIRST=0: shift right, D enters at bit WIDTH-1.
// - Latency: DP/valid update on the edge that samples the last bit. There is no extra cycle.
// - Handshake: ack=1 with valid=1 clears valid on the next edge. ack with valid=0 is ignored. DP holds its value until the next word completes.
// - Simultaneous completion and ack: new word loaded, valid stays 1, overrun unchanged.
// - Completion while valid=1 and ack=0: DP overwritten, valid stays 1, overrun<=1. overrun clears only on reset.
// - start=1 in any state: count=0, partial bits discarded, state IDLE; DP/valid/overrun unaffected.
//   If LS=1 on the same edge, D is taken as bit 1 of a new frame (count=1, SHIFT).
// - A single-bit word never occurs (WIDTH>=2).
// - Count width: $clog2(WIDTH+1). Count never exceeds WIDTH-1 while in SHIFT.
// STRUCTURE
// - Package serial_pkg:
//   - typedef enum logic {IDLE, SHIFT} rx_state_t
//   - function cnt_w(width) returning $clog2(width+1)
//   - shared with the transmitter.
// - One sub-module, sipo_shift_core:
//   - WIDTH/MSB_FIRST shift register with enable and synchronous clear.
//   - Top level keeps the FSM, counter, handshake and overrun logic.
// TESTING (WIDTH=4, MSB_FIRST=1 unless stated)
// 1. Reset after 2 bits, release, then send 1,1,0,0 with LS=1
//    -> DP=0/valid=0 during reset; afterwards DP=4'hC, no leftover bits.
// 2. Contiguous 1,0,1,1 with LS=1
//    -> valid=1 and DP=4'hB on the 4th edge; busy=1 on edges 1-3, 0 after.
// 3. Bits 0,1,0,1 with LS=0 gaps of 2 cycles between bits
//    -> DP=4'h5 only after the 4th enabled bit; state held during gaps.
// 4. Word 4'hB, no ack, then word 4'h8
//    -> DP=8, valid=1, overrun=1. Repeat with ack on the completion edge -> overrun stays 0.
// 5. Two bits, then start=1 with LS=0, then 1,0,0,0
//    -> DP=4'h8. Repeat with start and LS=1 together on the first new bit -> same result.
// 6. MSB_FIRST=0, bits 1,1,0,1 -> DP=4'hB.
//    Then ack -> valid=0 next edge with DP still 4'hB.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared serial-link types and helpers (receiver FSM states, bit-counter width)
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} rx_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: WIDTH-bit serial-in shift register (en shifts d in, clr discards contents, nxt = value after this edge's shift); ports clk, rst (async low), en, clr, d, nxt
module sipo_shift_core #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] base;
  assign base = clr ? '0 : q;
  assign nxt = MSB_FIRST ? {base[WIDTH-2:0], d} : {d, base[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (en || clr) q <= en ? nxt : '0;
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles WIDTH serial bits (D sampled when LS=1, start restarts frame) into DP with valid/ack handshake, busy while mid-word, sticky overrun; rst async active-low
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             LS,
  input  logic             start,
  input  logic             ack,
  output logic [WIDTH-1:0] DP,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = cnt_w(WIDTH);
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, base_cnt;
  logic [WIDTH-1:0] word;
  logic done;
  sipo_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk(clk),
    .rst(rst),
    .en(LS),
    .clr(start),
    .d(D),
    .nxt(word)
  );
  always_comb begin
    base_cnt = start ? '0 : cnt;
    done = LS && (base_cnt == CW'(WIDTH - 1));
    cnt_n = done ? '0 : LS ? base_cnt + CW'(1) : base_cnt;
    state_n = done ? IDLE : LS ? SHIFT : start ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      DP <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (done) begin
        DP <= word;
        valid <= 1'b1;
        if (valid && !ack) overrun <= 1'b1;
      end else if (ack) valid <= 1'b0;
    end
  assign busy = state == SHIFT;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed self-checking bench for serial_word_receiver (MSB-first and LSB-first instances)
module tb_serial_word_receiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic D = 1'b0, LS = 1'b0, start = 1'b0, ack = 1'b0;
  logic [3:0] dp1, dp0;
  logic valid1, busy1, ovr1, valid0, busy0, ovr0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .D(D), .LS(LS), .start(start), .ack(ack),
    .DP(dp1), .valid(valid1), .busy(busy1), .overrun(ovr1)
  );
  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .D(D), .LS(LS), .start(start), .ack(ack),
    .DP(dp0), .valid(valid0), .busy(busy0), .overrun(ovr0)
  );
  task automatic drive(input logic d, input logic ls, input logic s, input logic a);
    D = d;
    LS = ls;
    start = s;
    ack = a;
    @(posedge clk);
    #1;
    D = 1'b0;
    LS = 1'b0;
    start = 1'b0;
    ack = 1'b0;
  endtask
  task automatic send_word(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) drive(bits[i], 1'b1, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({dp1, valid1, busy1, ovr1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got dp=%h v=%b b=%b o=%b want 0/0/0/0", dp1, valid1, busy1, ovr1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_word(4'b1100);
    checks++;
    if (dp1 !== 4'hC || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_leftover got dp=%h v=%b want C/1", dp1, valid1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_contiguous();
    logic [3:0] bits = 4'b1011;
    for (int i = 3; i >= 1; i--) begin
      drive(bits[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
        errors++;
        $display("FAIL contig_busy edge%0d got b=%b v=%b want 1/0", 4 - i, busy1, valid1);
      end
    end
    drive(bits[0], 1'b1, 1'b0, 1'b0);
    checks++;
    if (dp1 !== 4'hB || valid1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL contig_word got dp=%h v=%b b=%b want B/1/0", dp1, valid1, busy1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_gaps();
    logic [3:0] bits = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      drive(bits[i], 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0 || dp1 !== 4'hB) begin
          errors++;
          $display("FAIL gap_hold bit%0d got b=%b v=%b dp=%h want 1/0/B", 4 - i, busy1, valid1, dp1);
        end
      end
    end
    checks++;
    if (dp1 !== 4'h5 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL gap_word got dp=%h v=%b want 5/1", dp1, valid1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_overrun();
    send_word(4'hB);
    send_word(4'h8);
    checks++;
    if (dp1 !== 4'h8 || valid1 !== 1'b1 || ovr1 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got dp=%h v=%b o=%b want 8/1/1", dp1, valid1, ovr1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr1 !== 1'b1 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky got o=%b v=%b want 1/0", ovr1, valid1);
    end
    do_reset();
    send_word(4'hB);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dp1 !== 4'h8 || valid1 !== 1'b1 || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL ack_on_complete got dp=%h v=%b o=%b want 8/1/0", dp1, valid1, ovr1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_start();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL start_idle got b=%b v=%b want 0/0", busy1, valid1);
    end
    send_word(4'h8);
    checks++;
    if (dp1 !== 4'h8 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL start_word got dp=%h v=%b want 8/1", dp1, valid1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL start_ls_busy got b=%b v=%b want 1/0", busy1, valid1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL start_ls_early got v=%b want 0", valid1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dp1 !== 4'h8 || valid1 !== 1'b1 || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL start_ls_word got dp=%h v=%b o=%b want 8/1/0", dp1, valid1, ovr1);
    end
  endtask
  task automatic test_lsb_first();
    do_reset();
    send_word(4'b1101);
    checks++;
    if (dp0 !== 4'hB || valid0 !== 1'b1) begin
      errors++;
      $display("FAIL lsb_word got dp=%h v=%b want B/1", dp0, valid0);
    end
    checks++;
    if (dp1 !== 4'hD) begin
      errors++;
      $display("FAIL msb_same_bits got dp=%h want D", dp1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (valid0 !== 1'b0 || dp0 !== 4'hB) begin
      errors++;
      $display("FAIL lsb_ack got v=%b dp=%h want 0/B", valid0, dp0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (valid0 !== 1'b0 || ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle got v=%b o=%b want 0/0", valid0, ovr0);
    end
  endtask
  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_overrun();
    test_start();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
